// File: rtl/axi_master_read_port_if.sv
// AXI4 read-address and read-data channel bundle between a read master and its slave.
interface axi_master_read_port_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]   ARID_M;
  logic [ADDR_W-1:0] ARADDR_M;
  logic [LEN_W-1:0]  ARLEN_M;
  logic [2:0]        ARSIZE_M;
  logic [1:0]        ARBURST_M;
  logic              ARVALID_M;
  logic              ARREADY_M;

  logic [ID_W-1:0]   RID_M;
  logic [DATA_W-1:0] RDATA_M;
  logic [1:0]        RRESP_M;
  logic              RLAST_M;
  logic              RVALID_M;
  logic              RREADY_M;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    input  ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
  );

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M, RREADY_M,
    output ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M
  );
endinterface

// File: rtl/axi_master_read_port.sv
// AXI4 read master engine: issues one INCR read burst per request, forwards the
// returned beats one registered cycle later and pulses done with a sticky error flag.
module axi_master_read_port #(
  parameter int              ID_W      = 4,
  parameter logic [ID_W-1:0] MASTER_ID = '0,
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              LEN_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [ADDR_W-1:0]      addr_i,
  input  logic [LEN_W-1:0]       len_i,
  output logic                   busy_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   rdata_vld_o,
  output logic                   rdata_last_o,
  output logic                   done_o,
  output logic                   err_o,
  axi_master_read_port_if.master axi
);

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ADDR = 4'b0010,
    DATA = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ID_W-1:0]   arId_q, arId_d;
  logic [2:0]        arSize_q, arSize_d;
  logic [1:0]        arBurst_q, arBurst_d;
  logic [LEN_W:0]    beatCnt_q, beatCnt_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdataVld_q, rdataVld_d;
  logic              rdataLast_q, rdataLast_d;

  logic [12:0]       reqEnd;
  logic              crosses4k;
  logic [LEN_W:0]    lenPlusOne;
  logic [LEN_W:0]    beatCntInc;
  logic              unusedAddrLsbs;

  // The burst end offset inside its 4KB page; 13 bits hold page offset plus burst bytes.
  assign reqEnd         = {1'b0, addr_i[11:2], 2'b00} + (13'(len_i) << 2) + 13'd4;
  assign crosses4k      = (reqEnd > 13'd4096);
  assign lenPlusOne     = {1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1};
  assign beatCntInc     = beatCnt_q + {{LEN_W{1'b0}}, 1'b1};
  assign unusedAddrLsbs = ^addr_i[1:0];

  // Next-state and datapath decisions for the request/address/data/done sequence.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    arId_d      = arId_q;
    arSize_d    = arSize_q;
    arBurst_d   = arBurst_q;
    beatCnt_d   = beatCnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rdataVld_d  = 1'b0;
    rdataLast_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          addr_d    = {addr_i[ADDR_W-1:2], 2'b00};
          len_d     = len_i;
          beatCnt_d = '0;
          err_d     = 1'b0;
          if (crosses4k) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            arId_d    = MASTER_ID;
            arSize_d  = 3'b010;
            arBurst_d = 2'b01;
            state_d   = ADDR;
          end
        end
      end
      ADDR: begin
        if (axi.ARREADY_M) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (axi.RVALID_M) begin
          if (axi.RID_M != MASTER_ID) begin
            err_d = 1'b1;
          end else begin
            if (beatCnt_q == lenPlusOne) begin
              err_d = 1'b1;
            end else begin
              rdata_d     = axi.RDATA_M;
              rdataVld_d  = 1'b1;
              rdataLast_d = axi.RLAST_M;
              beatCnt_d   = beatCntInc;
            end
            if (axi.RRESP_M != 2'b00) begin
              err_d = 1'b1;
            end
            if (axi.RLAST_M) begin
              state_d = DONE;
              if (beatCnt_d != lenPlusOne) begin
                err_d = 1'b1;
              end
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction and clears every output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      arId_q      <= '0;
      arSize_q    <= '0;
      arBurst_q   <= '0;
      beatCnt_q   <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rdataVld_q  <= 1'b0;
      rdataLast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      arId_q      <= arId_d;
      arSize_q    <= arSize_d;
      arBurst_q   <= arBurst_d;
      beatCnt_q   <= beatCnt_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rdataVld_q  <= rdataVld_d;
      rdataLast_q <= rdataLast_d;
    end
  end

  // ARVALID and RREADY decode from disjoint states, so they can never overlap.
  assign axi.ARVALID_M = (state_q == ADDR);
  assign axi.RREADY_M  = (state_q == DATA);
  assign axi.ARID_M    = arId_q;
  assign axi.ARADDR_M  = addr_q;
  assign axi.ARLEN_M   = len_q;
  assign axi.ARSIZE_M  = arSize_q;
  assign axi.ARBURST_M = arBurst_q;

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign rdata_vld_o  = rdataVld_q;
  assign rdata_last_o = rdataLast_q;

endmodule

// File: tb/tb_axi_master_read_port.sv
// Self-checking bench for axi_master_read_port: a simple AXI slave driver, a negedge
// monitor and a transaction-level model of which beats get forwarded and when err is set.
module tb_axi_master_read_port;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic [31:0] addr_i;
  logic [3:0]  len_i;
  logic        busy_o;
  logic [31:0] rdata_o;
  logic        rdata_vld_o;
  logic        rdata_last_o;
  logic        done_o;
  logic        err_o;

  axi_master_read_port_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) axi ();

  axi_master_read_port #(
    .ID_W(4), .MASTER_ID(4'd0), .ADDR_W(32), .DATA_W(32), .LEN_W(4)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .len_i(len_i),
    .busy_o(busy_o), .rdata_o(rdata_o), .rdata_vld_o(rdata_vld_o),
    .rdata_last_o(rdata_last_o), .done_o(done_o), .err_o(err_o), .axi(axi.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Beats the slave will return for the next transaction.
  logic [3:0]  qRid[$];
  logic [31:0] qData[$];
  logic [1:0]  qResp[$];
  logic        qLast[$];

  // Model expectations.
  logic [31:0] expData[$];
  logic        expLast[$];
  logic        expErr;
  logic        expAr;

  // Observations.
  logic [31:0] obsData[$];
  logic        obsLast[$];
  int          obsDone, obsArCount, protoViol;
  logic        obsErr, obsTimeout, monEn;
  logic [31:0] obsArAddr;
  logic [3:0]  obsArLen, obsArId;
  logic [2:0]  obsArSize;
  logic [1:0]  obsArBurst;
  int          cyc = 0;
  int          reqCyc, firstArvCyc, lastHsCyc, doneCyc, lastVldCyc;
  logic        prevArv, prevArr;
  logic [31:0] prevAddr;

  // Samples the DUT mid-cycle: collects forwarded beats, done/err and AR protocol rules.
  always @(negedge clk) begin
    cyc++;
    if (monEn) begin
      if (rdata_vld_o) begin
        obsData.push_back(rdata_o);
        obsLast.push_back(rdata_last_o);
        lastVldCyc = cyc;
      end
      if (done_o) begin
        obsDone++;
        obsErr  = err_o;
        doneCyc = cyc;
      end
      if (axi.ARVALID_M && firstArvCyc < 0) firstArvCyc = cyc;
      if (axi.ARVALID_M && axi.RREADY_M) protoViol++;
      if (prevArv && !prevArr && (!axi.ARVALID_M || axi.ARADDR_M !== prevAddr)) protoViol++;
      prevArv  = axi.ARVALID_M;
      prevArr  = axi.ARREADY_M;
      prevAddr = axi.ARADDR_M;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_beats();
    qRid.delete(); qData.delete(); qResp.delete(); qLast.delete();
  endtask

  task automatic push_beat(input logic [3:0] rid, input logic [31:0] data,
                           input logic [1:0] resp, input logic last);
    qRid.push_back(rid); qData.push_back(data); qResp.push_back(resp); qLast.push_back(last);
  endtask

  // Transaction-level reference: page-crossing rule, then walk the returned beats.
  task automatic build_expected(input logic [31:0] addr, input logic [3:0] len);
    int beats = int'(len) + 1;
    int offset = int'(addr & 32'h0000_0FFC);
    int cnt = 0;
    expData.delete(); expLast.delete();
    expErr = 1'b0;
    expAr  = (offset + 4 * beats <= 4096);
    if (!expAr) begin
      expErr = 1'b1;
      return;
    end
    foreach (qRid[i]) begin
      if (qRid[i] != 4'd0) begin
        expErr = 1'b1;
        continue;
      end
      if (cnt == beats) expErr = 1'b1;
      else begin
        expData.push_back(qData[i]);
        expLast.push_back(qLast[i]);
        cnt++;
      end
      if (qResp[i] != 2'b00) expErr = 1'b1;
      if (qLast[i]) begin
        if (cnt != beats) expErr = 1'b1;
        break;
      end
    end
  endtask

  function automatic int data_diffs();
    int n = (obsData.size() != expData.size()) ? 1 : 0;
    for (int i = 0; i < obsData.size() && i < expData.size(); i++)
      if (obsData[i] !== expData[i] || obsLast[i] !== expLast[i]) n++;
    return n;
  endfunction

  // Drives one request and plays the queued beats as the AXI slave.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] len,
                         input int arDelay, input int gap);
    int guard;
    obsData.delete(); obsLast.delete();
    obsDone = 0; obsArCount = 0; protoViol = 0; obsErr = 1'bx; obsTimeout = 1'b0;
    firstArvCyc = -1; lastHsCyc = -1; doneCyc = -1; lastVldCyc = -1;
    prevArv = 1'b0; prevArr = 1'b0; prevAddr = '0;
    monEn = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b1; addr_i = addr; len_i = len;
    @(posedge clk); #1;
    req_i = 1'b0; reqCyc = cyc;
    guard = 0;
    while (!axi.ARVALID_M && !done_o && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    if (axi.ARVALID_M) begin
      repeat (arDelay) begin @(posedge clk); #1; end
      axi.ARREADY_M = 1'b1;
      obsArAddr = axi.ARADDR_M; obsArLen = axi.ARLEN_M; obsArId = axi.ARID_M;
      obsArSize = axi.ARSIZE_M; obsArBurst = axi.ARBURST_M;
      @(posedge clk); #1;
      axi.ARREADY_M = 1'b0;
      obsArCount++;
      foreach (qRid[i]) begin
        repeat (gap) begin @(posedge clk); #1; end
        axi.RVALID_M = 1'b1; axi.RID_M = qRid[i]; axi.RDATA_M = qData[i];
        axi.RRESP_M = qResp[i]; axi.RLAST_M = qLast[i];
        guard = 0;
        while (!axi.RREADY_M && guard < 50) begin @(posedge clk); #1; guard++; end
        if (guard >= 50) begin
          obsTimeout = 1'b1; axi.RVALID_M = 1'b0;
          break;
        end
        @(posedge clk); #1;
        lastHsCyc = cyc;
        axi.RVALID_M = 1'b0;
      end
    end else if (!done_o) begin
      obsTimeout = 1'b1;
    end
    guard = 0;
    while (busy_o && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) obsTimeout = 1'b1;
    @(posedge clk); #1;
    monEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b0; addr_i = '0; len_i = '0; monEn = 1'b0;
    axi.ARREADY_M = 1'b0; axi.RVALID_M = 1'b0; axi.RID_M = '0; axi.RDATA_M = '0;
    axi.RRESP_M = '0; axi.RLAST_M = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy_o !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy_o); else passed++;
    total++; if (done_o !== 1'b0 || err_o !== 1'b0) $display("[TB] FAIL reset_done_err: got %b/%b want 0/0", done_o, err_o); else passed++;
    total++; if (rdata_o !== 32'h0 || rdata_vld_o !== 1'b0 || rdata_last_o !== 1'b0) $display("[TB] FAIL reset_rdata: got %h/%b/%b want 0", rdata_o, rdata_vld_o, rdata_last_o); else passed++;
    total++; if (axi.ARVALID_M !== 1'b0 || axi.RREADY_M !== 1'b0) $display("[TB] FAIL reset_valid_ready: got %b/%b want 0/0", axi.ARVALID_M, axi.RREADY_M); else passed++;
    total++; if (axi.ARADDR_M !== 32'h0 || axi.ARLEN_M !== 4'h0 || axi.ARSIZE_M !== 3'h0 || axi.ARBURST_M !== 2'h0) $display("[TB] FAIL reset_ar_payload: got %h/%h/%h/%h want 0", axi.ARADDR_M, axi.ARLEN_M, axi.ARSIZE_M, axi.ARBURST_M); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    clear_beats();
    push_beat(4'd0, 32'hDEADBEEF, 2'b00, 1'b1);
    build_expected(32'h1004, 4'd0);
    run_txn(32'h1004, 4'd0, 2, 0);
    total++; if (obsTimeout !== 1'b0) $display("[TB] FAIL single_timeout: got %b want 0", obsTimeout); else passed++;
    total++; if (obsArAddr !== 32'h1004 || obsArLen !== 4'd0) $display("[TB] FAIL single_ar: got %h/%0d want 1004/0", obsArAddr, obsArLen); else passed++;
    total++; if (obsArSize !== 3'b010 || obsArBurst !== 2'b01 || obsArId !== 4'd0) $display("[TB] FAIL single_ar_fixed: got %b/%b/%h want 010/01/0", obsArSize, obsArBurst, obsArId); else passed++;
    total++; if (obsData.size() !== 1 || data_diffs() !== 0) $display("[TB] FAIL single_data: got %0d beats, %0d diffs want 1/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsData.size() == 1 && (obsData[0] !== 32'hDEADBEEF || obsLast[0] !== 1'b1)) $display("[TB] FAIL single_beat: got %h last %b want deadbeef/1", obsData[0], obsLast[0]); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b0) $display("[TB] FAIL single_done: got done %0d err %b want 1/0", obsDone, obsErr); else passed++;
    total++; if (firstArvCyc !== reqCyc + 1) $display("[TB] FAIL single_arvalid_lat: got %0d want %0d", firstArvCyc, reqCyc + 1); else passed++;
    total++; if (doneCyc !== lastHsCyc + 1 || lastVldCyc !== lastHsCyc + 1) $display("[TB] FAIL single_done_lat: got done %0d vld %0d want %0d", doneCyc, lastVldCyc, lastHsCyc + 1); else passed++;
    total++; if (protoViol !== 0) $display("[TB] FAIL single_protocol: got %0d violations want 0", protoViol); else passed++;
  endtask

  task automatic test_burst();
    clear_beats();
    push_beat(4'd0, 32'h11, 2'b00, 1'b0);
    push_beat(4'd0, 32'h22, 2'b00, 1'b0);
    push_beat(4'd0, 32'h33, 2'b00, 1'b0);
    push_beat(4'd0, 32'h44, 2'b00, 1'b1);
    build_expected(32'h2000, 4'd3);
    run_txn(32'h2000, 4'd3, 0, 2);
    total++; if (obsTimeout !== 1'b0) $display("[TB] FAIL burst_timeout: got %b want 0", obsTimeout); else passed++;
    total++; if (obsArAddr !== 32'h2000 || obsArLen !== 4'd3) $display("[TB] FAIL burst_ar: got %h/%0d want 2000/3", obsArAddr, obsArLen); else passed++;
    total++; if (obsData.size() !== 4 || data_diffs() !== 0) $display("[TB] FAIL burst_data: got %0d beats, %0d diffs want 4/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b0) $display("[TB] FAIL burst_done: got done %0d err %b want 1/0", obsDone, obsErr); else passed++;
    total++; if (doneCyc !== lastHsCyc + 1) $display("[TB] FAIL burst_done_lat: got %0d want %0d", doneCyc, lastHsCyc + 1); else passed++;
    total++; if (protoViol !== 0) $display("[TB] FAIL burst_protocol: got %0d violations want 0", protoViol); else passed++;
  endtask

  task automatic test_slverr();
    clear_beats();
    push_beat(4'd0, 32'hA0, 2'b00, 1'b0);
    push_beat(4'd0, 32'hA1, 2'b10, 1'b0);
    push_beat(4'd0, 32'hA2, 2'b00, 1'b0);
    push_beat(4'd0, 32'hA3, 2'b00, 1'b1);
    build_expected(32'h2100, 4'd3);
    run_txn(32'h2100, 4'd3, 1, 0);
    total++; if (obsData.size() !== 4 || data_diffs() !== 0) $display("[TB] FAIL slverr_data: got %0d beats, %0d diffs want 4/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b1) $display("[TB] FAIL slverr_err: got done %0d err %b want 1/1", obsDone, obsErr); else passed++;
    clear_beats();
    push_beat(4'd0, 32'hB0, 2'b00, 1'b0);
    push_beat(4'd0, 32'hB1, 2'b00, 1'b1);
    build_expected(32'h2040, 4'd1);
    run_txn(32'h2040, 4'd1, 0, 0);
    total++; if (obsDone !== 1 || obsErr !== 1'b0) $display("[TB] FAIL slverr_clean_after: got done %0d err %b want 1/0", obsDone, obsErr); else passed++;
    total++; if (data_diffs() !== 0) $display("[TB] FAIL slverr_clean_data: got %0d diffs want 0", data_diffs()); else passed++;
  endtask

  task automatic test_4kb();
    clear_beats();
    build_expected(32'h0FF8, 4'd3);
    run_txn(32'h0FF8, 4'd3, 0, 0);
    total++; if (firstArvCyc !== -1 || obsArCount !== 0) $display("[TB] FAIL 4kb_no_ar: got first arvalid %0d count %0d want -1/0", firstArvCyc, obsArCount); else passed++;
    total++; if (obsDone !== 1 || doneCyc !== reqCyc + 1) $display("[TB] FAIL 4kb_done_lat: got done %0d at %0d want 1 at %0d", obsDone, doneCyc, reqCyc + 1); else passed++;
    total++; if (obsErr !== expErr || obsErr !== 1'b1) $display("[TB] FAIL 4kb_err: got %b want 1", obsErr); else passed++;
    total++; if (obsData.size() !== 0 || obsTimeout !== 1'b0) $display("[TB] FAIL 4kb_quiet: got %0d beats timeout %b want 0/0", obsData.size(), obsTimeout); else passed++;
    // A burst ending exactly on the page boundary is legal.
    clear_beats();
    for (int i = 0; i < 4; i++) push_beat(4'd0, 32'hF00 + 32'(i), 2'b00, i == 3);
    build_expected(32'h0FF0, 4'd3);
    run_txn(32'h0FF0, 4'd3, 0, 0);
    total++; if (obsArCount !== 1 || obsArAddr !== 32'h0FF0) $display("[TB] FAIL 4kb_edge_ar: got count %0d addr %h want 1/ff0", obsArCount, obsArAddr); else passed++;
    total++; if (obsErr !== 1'b0 || data_diffs() !== 0) $display("[TB] FAIL 4kb_edge_data: got err %b diffs %0d want 0/0", obsErr, data_diffs()); else passed++;
  endtask

  task automatic test_early_rlast();
    clear_beats();
    push_beat(4'd0, 32'h01, 2'b00, 1'b0);
    push_beat(4'd0, 32'h02, 2'b00, 1'b1);
    build_expected(32'h5000, 4'd3);
    run_txn(32'h5000, 4'd3, 0, 1);
    total++; if (obsData.size() !== 2 || data_diffs() !== 0) $display("[TB] FAIL early_data: got %0d beats, %0d diffs want 2/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b1) $display("[TB] FAIL early_err: got done %0d err %b want 1/1", obsDone, obsErr); else passed++;
    total++; if (doneCyc !== lastHsCyc + 1 || obsTimeout !== 1'b0) $display("[TB] FAIL early_done_lat: got %0d timeout %b want %0d/0", doneCyc, obsTimeout, lastHsCyc + 1); else passed++;
  endtask

  task automatic test_bad_rid();
    clear_beats();
    push_beat(4'd0, 32'hA1, 2'b00, 1'b0);
    push_beat(4'hF, 32'hBAD, 2'b00, 1'b1);
    push_beat(4'd0, 32'hA2, 2'b00, 1'b1);
    build_expected(32'h6000, 4'd1);
    run_txn(32'h6000, 4'd1, 0, 0);
    total++; if (obsData.size() !== 2 || data_diffs() !== 0) $display("[TB] FAIL badrid_data: got %0d beats, %0d diffs want 2/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b1) $display("[TB] FAIL badrid_err: got done %0d err %b want 1/1", obsDone, obsErr); else passed++;
    // Extra counted beat past the burst length is swallowed and flagged.
    clear_beats();
    push_beat(4'd0, 32'hC1, 2'b00, 1'b0);
    push_beat(4'd0, 32'hC2, 2'b00, 1'b1);
    build_expected(32'h6100, 4'd0);
    run_txn(32'h6100, 4'd0, 0, 0);
    total++; if (obsData.size() !== 1 || data_diffs() !== 0) $display("[TB] FAIL excess_data: got %0d beats, %0d diffs want 1/0", obsData.size(), data_diffs()); else passed++;
    total++; if (obsDone !== 1 || obsErr !== 1'b1) $display("[TB] FAIL excess_err: got done %0d err %b want 1/1", obsDone, obsErr); else passed++;
  endtask

  task automatic test_reset_mid();
    monEn = 1'b0;
    @(posedge clk); #1;
    req_i = 1'b1; addr_i = 32'h4000; len_i = 4'd3;
    @(posedge clk); #1;
    req_i = 1'b0;
    axi.ARREADY_M = 1'b1;
    @(posedge clk); #1;
    axi.ARREADY_M = 1'b0;
    axi.RVALID_M = 1'b1; axi.RID_M = 4'd0; axi.RDATA_M = 32'hA5A50001;
    axi.RRESP_M = 2'b10; axi.RLAST_M = 1'b0;
    @(posedge clk); #1;
    axi.RVALID_M = 1'b0; axi.RRESP_M = 2'b00;
    total++; if (busy_o !== 1'b1 || rdata_vld_o !== 1'b1 || rdata_o !== 32'hA5A50001) $display("[TB] FAIL rstmid_pre: got busy %b vld %b data %h want 1/1/a5a50001", busy_o, rdata_vld_o, rdata_o); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) $display("[TB] FAIL rstmid_ctrl: got busy %b done %b err %b want 0", busy_o, done_o, err_o); else passed++;
    total++; if (rdata_o !== 32'h0 || rdata_vld_o !== 1'b0 || rdata_last_o !== 1'b0) $display("[TB] FAIL rstmid_rdata: got %h/%b/%b want 0", rdata_o, rdata_vld_o, rdata_last_o); else passed++;
    total++; if (axi.ARVALID_M !== 1'b0 || axi.RREADY_M !== 1'b0 || axi.ARADDR_M !== 32'h0 || axi.ARLEN_M !== 4'h0) $display("[TB] FAIL rstmid_axi: got %b/%b/%h/%h want 0", axi.ARVALID_M, axi.RREADY_M, axi.ARADDR_M, axi.ARLEN_M); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_beats();
    push_beat(4'd0, 32'h3000CAFE, 2'b00, 1'b1);
    build_expected(32'h3000, 4'd0);
    run_txn(32'h3000, 4'd0, 1, 0);
    total++; if (obsArAddr !== 32'h3000 || obsDone !== 1 || obsErr !== 1'b0) $display("[TB] FAIL rstmid_after: got addr %h done %0d err %b want 3000/1/0", obsArAddr, obsDone, obsErr); else passed++;
    total++; if (data_diffs() !== 0 || obsTimeout !== 1'b0) $display("[TB] FAIL rstmid_after_data: got diffs %0d timeout %b want 0/0", data_diffs(), obsTimeout); else passed++;
  endtask

  task automatic test_random();
    logic [3:0]  len;
    logic [31:0] addr;
    int          offset;
    for (int it = 0; it < 10; it++) begin
      len = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) offset = 4096 - 4 * $urandom_range(1, 16);
      else offset = 4 * $urandom_range(0, 1000);
      addr = ($urandom & 32'hFFFF_F000) | 32'(offset) | 32'($urandom_range(0, 3));
      clear_beats();
      for (int b = 0; b <= int'(len); b++) begin
        if ($urandom_range(0, 7) == 0)
          push_beat(4'($urandom_range(1, 15)), $urandom, 2'b00, 1'($urandom_range(0, 1)));
        push_beat(4'd0, $urandom, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00, b == int'(len));
      end
      build_expected(addr, len);
      run_txn(addr, len, $urandom_range(0, 3), $urandom_range(0, 2));
      total++; if (obsTimeout !== 1'b0) $display("[TB] FAIL rand%0d_timeout: got %b want 0", it, obsTimeout); else passed++;
      total++; if (data_diffs() !== 0) $display("[TB] FAIL rand%0d_data: got %0d beats, %0d diffs want %0d/0", it, obsData.size(), data_diffs(), expData.size()); else passed++;
      total++; if (obsDone !== 1 || obsErr !== expErr) $display("[TB] FAIL rand%0d_err: got done %0d err %b want 1/%b", it, obsDone, obsErr, expErr); else passed++;
      total++; if (obsArCount !== (expAr ? 1 : 0)) $display("[TB] FAIL rand%0d_ar: got %0d handshakes want %0d", it, obsArCount, expAr ? 1 : 0); else passed++;
      total++; if (protoViol !== 0) $display("[TB] FAIL rand%0d_protocol: got %0d violations want 0", it, protoViol); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_slverr();
    test_4kb();
    test_early_rlast();
    test_bad_rid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
